// File: rtl/nixie_pkg.sv
// Shared constants and types for the nixie_scan_reader display readback block.
// Segment encoding: bit0=a .. bit6=g, active high.
package nixie_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational 7-segment pattern decoder.
// Macro HEX_DECODE_EN: when defined, A..F glyphs are also recognised.
module seg7_to_bin
  import nixie_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_hit,
  output logic       o_blank,
  output logic [3:0] o_val
);

  // Map a segment pattern to its digit value, or flag it as blank/unknown.
  always_comb begin
    o_hit   = 1'b1;
    o_blank = 1'b0;
    o_val   = 4'h0;
    case (i_seg)
      SEG_0: o_val = 4'h0;
      SEG_1: o_val = 4'h1;
      SEG_2: o_val = 4'h2;
      SEG_3: o_val = 4'h3;
      SEG_4: o_val = 4'h4;
      SEG_5: o_val = 4'h5;
      SEG_6: o_val = 4'h6;
      SEG_7: o_val = 4'h7;
      SEG_8: o_val = 4'h8;
      SEG_9: o_val = 4'h9;
`ifdef HEX_DECODE_EN
      SEG_A: o_val = 4'hA;
      SEG_B: o_val = 4'hB;
      SEG_C: o_val = 4'hC;
      SEG_D: o_val = 4'hD;
      SEG_E: o_val = 4'hE;
      SEG_F: o_val = 4'hF;
`endif
      SEG_BLANK: begin
        o_hit   = 1'b0;
        o_blank = 1'b1;
      end
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/nixie_scan_reader.sv
// Samples a scanned 7-segment display bus and recovers each digit as 4-bit binary.
// A {sel,seg} pattern must hold for STABLE_CYC synchronised samples before it is
// committed once into the slot addressed by the one-hot select.
// Macro HEX_DECODE_EN (in seg7_to_bin) extends the decode table to A..F.
module nixie_scan_reader
  import nixie_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   sel_in,
  input  logic                  clr_i,
  output logic [4*N_DIGITS-1:0] digits_o,
  output logic [N_DIGITS-1:0]   valid_o,
  output logic                  err_o,
  output logic                  frame_o
);

  localparam int             CW        = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]  LP_STABLE = CW'(STABLE_CYC);
  localparam logic [CW-1:0]  LP_ONE    = CW'(1);

  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [N_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_sel_prev;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  state_t                r_state, w_state_nxt;
  logic                  w_same, w_sel_ok, w_commit;
  logic                  w_hit, w_blank;
  logic [3:0]            w_val;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_valid, r_mask, w_mask_nxt;
  logic                  r_err, r_frame;

  // Two-flop synchroniser on the pins, then the previous-sample compare register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1   <= 7'h00;
      r_seg_s2   <= 7'h00;
      r_seg_prev <= 7'h00;
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_sel_prev <= '0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_sel_s1   <= sel_in;
      r_sel_s2   <= r_sel_s1;
      r_sel_prev <= r_sel_s2;
    end
  end

  assign w_same    = (r_sel_s2 == r_sel_prev) && (r_seg_s2 == r_seg_prev);
  assign w_sel_ok  = (r_sel_s2 != '0) && ((r_sel_s2 & (r_sel_s2 - N_DIGITS'(1))) == '0);
  assign w_cnt_inc = (r_cnt == LP_STABLE) ? r_cnt : (r_cnt + LP_ONE);

  // FSM state and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a change of {sel,seg} starts a new run counted from one sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE, ST_SETTLE, ST_COMMIT, ST_HELD: begin
        if (r_state == ST_COMMIT) begin
          w_commit = 1'b1;
        end else begin
          w_commit = 1'b0;
        end
        if (r_state == ST_IDLE || !w_same) begin
          if (w_sel_ok) begin
            w_cnt_nxt   = LP_ONE;
            w_state_nxt = (LP_ONE == LP_STABLE) ? ST_COMMIT : ST_SETTLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_state == ST_SETTLE) begin
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == LP_STABLE) ? ST_COMMIT : ST_SETTLE;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  seg7_to_bin u_dec (
    .i_seg   (r_seg_prev),
    .o_hit   (w_hit),
    .o_blank (w_blank),
    .o_val   (w_val)
  );

  assign w_mask_nxt = r_mask | r_sel_prev;

  // Commit the stable pattern into its slot; clear has priority over a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_mask   <= '0;
      r_err    <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_frame <= 1'b0;
      if (clr_i) begin
        r_valid <= '0;
        r_mask  <= '0;
      end else if (w_commit) begin
        for (int k = 0; k < N_DIGITS; k++) begin
          if (r_sel_prev[k]) begin
            r_valid[k] <= w_hit;
            if (w_hit) begin
              r_digits[4*k +: 4] <= w_val;
            end
          end
        end
        r_err <= !w_hit && !w_blank;
        if (w_mask_nxt == '1) begin
          r_frame <= 1'b1;
          r_mask  <= '0;
        end else begin
          r_mask  <= w_mask_nxt;
        end
      end
    end
  end

  assign digits_o = r_digits;
  assign valid_o  = r_valid;
  assign err_o    = r_err;
  assign frame_o  = r_frame;

endmodule

// File: tb/tb_nixie_scan_reader.sv
// Self-checking bench for nixie_scan_reader: directed scenarios followed by random
// runs, checked every cycle against a run-length reference model.
module tb_nixie_scan_reader;

  localparam int N_DIGITS   = 4;
  localparam int STABLE_CYC = 4;
`ifdef HEX_DECODE_EN
  localparam int N_VAL = 16;
`else
  localparam int N_VAL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h00;
  logic [3:0]  sel_in = 4'h0;
  logic        clr_i = 1'b0;
  logic [15:0] digits_o;
  logic [3:0]  valid_o;
  logic        err_o;
  logic        frame_o;

  nixie_scan_reader #(.N_DIGITS(N_DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in), .clr_i(clr_i),
    .digits_o(digits_o), .valid_o(valid_o), .err_o(err_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  // Reference glyph table: entry i displays value i.
  logic [6:0] m_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_mask;
  logic        m_err, m_frame;
  logic [10:0] run_val;
  int          run_len;
  bit          run_none;
  int          cyc = 0;
  int          pend_cyc[$];
  logic [10:0] pend_pat[$];

  task automatic lookup(input logic [6:0] seg, output bit found, output logic [3:0] v);
    found = 1'b0;
    v = 4'h0;
    for (int i = 0; i < N_VAL; i++) begin
      if (m_pat[i] == seg) begin
        found = 1'b1;
        v = 4'(i);
      end
    end
  endtask

  task automatic model_reset();
    m_digits = 16'h0000; m_valid = 4'h0; m_mask = 4'h0;
    m_err = 1'b0; m_frame = 1'b0;
    run_none = 1'b1; run_len = 0; run_val = 11'h000;
    pend_cyc.delete(); pend_pat.delete();
  endtask

  // Track runs of identical pins; a one-hot run reaching STABLE_CYC lands 3 cycles later.
  task automatic model_apply(input logic [3:0] sel, input logic [6:0] seg);
    logic [10:0] p;
    p = {sel, seg};
    if (run_none || p != run_val) begin
      run_val = p; run_len = 1; run_none = 1'b0;
    end else begin
      run_len++;
    end
    if (run_len == STABLE_CYC && $countones(sel) == 1) begin
      pend_cyc.push_back(cyc + 3);
      pend_pat.push_back(p);
    end
  endtask

  task automatic model_edge(input logic clr);
    bit          have, found;
    logic [10:0] p;
    logic [3:0]  v;
    m_err = 1'b0; m_frame = 1'b0;
    have = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc);
    p = 11'h000;
    if (have) begin
      void'(pend_cyc.pop_front());
      p = pend_pat.pop_front();
    end
    if (clr) begin
      m_valid = 4'h0; m_mask = 4'h0;
    end else if (have) begin
      lookup(p[6:0], found, v);
      for (int k = 0; k < 4; k++) begin
        if (p[7+k]) begin
          m_valid[k] = found;
          if (found) m_digits[4*k +: 4] = v;
        end
      end
      m_err = !found && (p[6:0] != 7'h00);
      m_mask = m_mask | p[10:7];
      if (m_mask == 4'hF) begin
        m_frame = 1'b1; m_mask = 4'h0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digits"}, digits_o, m_digits);
    chk({tag, ".valid"}, {12'h000, valid_o}, {12'h000, m_valid});
    chk({tag, ".err"}, {15'h0000, err_o}, {15'h0000, m_err});
    chk({tag, ".frame"}, {15'h0000, frame_o}, {15'h0000, m_frame});
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic clr, input string tag);
    sel_in = sel; seg_in = seg; clr_i = clr;
    model_apply(sel, seg);
    @(posedge clk);
    #1;
    model_edge(clr);
    check_all(tag);
    cyc++;
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n, input string tag);
    for (int i = 0; i < n; i++) step(sel, seg, 1'b0, tag);
  endtask

  initial begin
    logic [3:0] r_sel;
    logic [6:0] r_seg;
    int         r_len;
    int         kind;

    // Power-on reset.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single digit held: '2' on slot 0.
    hold(4'b0001, 7'h5B, 10, "hold2");

    // Toggling faster than STABLE_CYC never commits.
    for (int t = 0; t < 4; t++) hold(4'b0010, (t % 2 == 0) ? 7'h06 : 7'h4F, 3, "toggle");
    hold(4'b0000, 7'h00, 3, "idle");

    // Full scan 0,7,8,9 after a clear -> one frame pulse.
    step(4'b0000, 7'h00, 1'b1, "clr0");
    hold(4'b0001, 7'h3F, 8, "scan0");
    hold(4'b0010, 7'h07, 8, "scan1");
    hold(4'b0100, 7'h7F, 8, "scan2");
    hold(4'b1000, 7'h6F, 8, "scan3");

    // 'A' glyph: error or hex value depending on configuration.
    hold(4'b0100, 7'h77, 10, "glyphA");

    // Blank on slot 1.
    hold(4'b0010, 7'h00, 10, "blank");

    // Multi-hot select never commits, then clear.
    hold(4'b0011, 7'h3F, 20, "multihot");
    step(4'b0011, 7'h3F, 1'b1, "clr1");
    hold(4'b0000, 7'h00, 4, "idle2");

    // Clear coinciding with a commit: commit dropped, pattern not re-committed.
    hold(4'b1000, 7'h66, 6, "clrc");
    step(4'b1000, 7'h66, 1'b1, "clrc_hit");
    hold(4'b1000, 7'h66, 6, "clrc_held");

    // Reset while counting (count 3), then a fresh stable run.
    hold(4'b0000, 7'h00, 3, "idle3");
    hold(4'b1000, 7'h6D, 5, "prerst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    hold(4'b1000, 7'h6D, 10, "postrst");

    // Random runs over valid, blank, unknown and hex glyphs.
    for (int r = 0; r < 80; r++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) r_sel = 4'b0000;
      else if (kind == 1) r_sel = 4'b0011 << $urandom_range(0, 2);
      else r_sel = 4'b0001 << $urandom_range(0, 3);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) r_seg = 7'h00;
      else if (kind == 1) r_seg = 7'($urandom());
      else r_seg = m_pat[$urandom_range(0, 15)];
      r_len = int'($urandom_range(1, 8));
      for (int i = 0; i < r_len; i++) step(r_sel, r_seg, ($urandom_range(0, 29) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
